// File: rtl/color_unhash.sv
// color_unhash: recovers the 5-bit gradient level from an RGB444 colour.
// Two-stage valid/ready pipeline with decaying peak-hold and error count.
module color_unhash #(
  parameter logic [15:0] DECAY_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_color,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_level,
  output logic        out_enable,
  output logic        out_err,
  input  logic        clear,
  output logic [4:0]  peak_level,
  output logic [7:0]  err_count
);

  logic        s1_valid_q, s1_valid_d;
  logic [11:0] s1_color_q, s1_color_d;
  logic        s2_valid_q, s2_valid_d;
  logic [4:0]  s2_level_q, s2_level_d;
  logic        s2_enable_q, s2_enable_d;
  logic        s2_err_q, s2_err_d;
  logic [4:0]  peak_q, peak_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic       s1_adv, s2_adv, deliver;
  logic [3:0] r, g, b;
  logic       is_black, on_hi, on_lo;
  logic [4:0] dec_level;
  logic       dec_en, dec_err;

  assign s2_adv  = !s2_valid_q | out_ready;
  assign s1_adv  = !s1_valid_q | s2_adv;
  assign deliver = s2_valid_q & out_ready;

  assign r = s1_color_q[11:8];
  assign g = s1_color_q[7:4];
  assign b = s1_color_q[3:0];

  // Mutually exclusive classes; 12'hFF0 falls in on_hi and decodes to 16.
  assign is_black = (s1_color_q == 12'h000);
  assign on_hi    = (b == 4'h0) && (g == 4'hF);
  assign on_lo    = (b == 4'h0) && (r == 4'hF) && (g != 4'hF);

  always_comb begin
    dec_level = 5'd0;
    dec_en    = 1'b1;
    dec_err   = 1'b0;
    unique case (1'b1)
      is_black: dec_en    = 1'b0;
      on_hi:    dec_level = 5'd31 - {1'b0, r};
      on_lo:    dec_level = {1'b0, g};
      default:  dec_err   = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_color_d  = s1_color_q;
    s2_valid_d  = s2_valid_q;
    s2_level_d  = s2_level_q;
    s2_enable_d = s2_enable_q;
    s2_err_d    = s2_err_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_color_d = in_color;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_level_d  = dec_level;
        s2_enable_d = dec_en;
        s2_err_d    = dec_err;
      end
    end
  end

  always_comb begin
    peak_d    = peak_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      peak_d    = 5'd0;
      timer_d   = 16'd0;
      err_cnt_d = 8'd0;
    end else begin
      if (deliver && s2_enable_q && !s2_err_q && (s2_level_q > peak_q)) begin
        peak_d  = s2_level_q;
        timer_d = 16'd0;
      end else if (peak_q != 5'd0) begin
        if (timer_q == DECAY_CYCLES - 16'd1) begin
          peak_d  = peak_q - 5'd1;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end else begin
        timer_d = 16'd0;
      end
      if (deliver && s2_err_q && (err_cnt_q != 8'hFF))
        err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_color_q  <= 12'h000;
      s2_valid_q  <= 1'b0;
      s2_level_q  <= 5'd0;
      s2_enable_q <= 1'b0;
      s2_err_q    <= 1'b0;
      peak_q      <= 5'd0;
      timer_q     <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_color_q  <= s1_color_d;
      s2_valid_q  <= s2_valid_d;
      s2_level_q  <= s2_level_d;
      s2_enable_q <= s2_enable_d;
      s2_err_q    <= s2_err_d;
      peak_q      <= peak_d;
      timer_q     <= timer_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = s2_valid_q;
  assign out_level  = s2_level_q;
  assign out_enable = s2_enable_q;
  assign out_err    = s2_err_q;
  assign peak_level = peak_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_color_unhash.sv
// tb_color_unhash: random and directed stimulus for color_unhash,
// checked against a gradient-search reference and a peak/age model.
module tb_color_unhash;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_color = 12'h000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_level;
  logic        out_enable;
  logic        out_err;
  logic        clear = 1'b0;
  logic [4:0]  peak_level;
  logic [7:0]  err_count;

  color_unhash #(.DECAY_CYCLES(16'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_color(in_color),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_level(out_level), .out_enable(out_enable), .out_err(out_err),
    .clear(clear), .peak_level(peak_level), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int lvl;
    bit en;
    bit err;
    int acc;
  } exp_t;

  exp_t q[$];

  // Forward gradient: level -> colour.
  function automatic logic [11:0] fwd(input int l);
    logic [3:0] n;
    if (l < 15) begin
      n = 4'(l);
      return {4'hF, n, 4'h0};
    end
    if (l == 15) return 12'hFF0;
    n = 4'(31 - l);
    return {n, 4'hF, 4'h0};
  endfunction

  // Inverse by search from the top; the 15/16 collision resolves to 16.
  function automatic exp_t ref_decode(input logic [11:0] c);
    exp_t e;
    e.lvl = 0; e.en = 1'b1; e.err = 1'b0; e.acc = 0;
    if (c == 12'h000) begin
      e.en = 1'b0;
      return e;
    end
    for (int l = 31; l >= 0; l--)
      if (fwd(l) == c) begin
        e.lvl = l;
        return e;
      end
    e.err = 1'b1;
    return e;
  endfunction

  int edges = 0;
  int level_set = 0;
  int t_set = 0;
  int errcnt_m = 0;
  bit stalled = 1'b0;
  logic [4:0] hold_lvl;
  logic hold_en, hold_err;

  // Peak is the last raise minus one step per D edges, floored at 0.
  function automatic int peak_at(input int e);
    int v;
    v = level_set - (e - t_set) / D;
    return (v < 0) ? 0 : v;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      level_set = 0;
      t_set = edges;
      errcnt_m = 0;
      stalled = 1'b0;
    end else begin
      int pk;
      exp_t e;
      pk = peak_at(edges);
      chk("peak", peak_level, pk);
      chk("errcnt", err_count, errcnt_m);
      chk("in_ready", in_ready, int'(q.size() < 2 || out_ready));
      chk("out_valid", out_valid,
          int'(q.size() > 0 && q[0].acc < edges));
      if (stalled) begin
        chk("stall_lvl", out_level, hold_lvl);
        chk("stall_en", out_enable, hold_en);
        chk("stall_err", out_err, hold_err);
      end
      stalled = out_valid && !out_ready;
      hold_lvl = out_level;
      hold_en = out_enable;
      hold_err = out_err;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("level", out_level, e.lvl);
          chk("enable", out_enable, e.en);
          chk("err", out_err, e.err);
          if (!clear && e.en && !e.err && e.lvl > pk) begin
            level_set = e.lvl;
            t_set = edges + 1;
          end
          if (!clear && e.err && errcnt_m < 255) errcnt_m++;
        end
      end
      if (clear) begin
        level_set = 0;
        t_set = edges + 1;
        errcnt_m = 0;
      end
      if (in_valid && in_ready) begin
        e = ref_decode(in_color);
        e.acc = edges + 1;
        q.push_back(e);
      end
    end
    edges++;
  end

  bit rnd_mode = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 40) == 0);
    end
  endtask

  task automatic send(input logic [11:0] c);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_color = c;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [11:0] c;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", out_level, 0);
    chk("rst_enable", out_enable, 0);
    chk("rst_err", out_err, 0);
    chk("rst_peak", peak_level, 0);
    chk("rst_errcnt", err_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    out_ready = 1'b1;
    for (int l = 0; l < 32; l++) send(fwd(l));
    drain();
    chk("sweep_errcnt", err_count, 0);

    send(12'h000);
    send(12'h00F);
    send(12'h8F1);
    drain();
    chk("errcnt_2", err_count, 2);

    fork
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        send(12'hF30);
        send(12'h5F0);
        send(12'h0AB);
        send(12'hFE0);
      end
    join
    drain();

    repeat (160) step();
    chk("peak_idle_zero", peak_level, 0);
    send(12'h0F0);
    drain();
    repeat (140) step();
    chk("peak_decayed", peak_level, 0);
    send(12'hBF0);
    drain();
    chk("peak_20", peak_level, 20);

    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: c = fwd($urandom_range(0, 31));
        3:       c = 12'h000;
        default: c = 12'($urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 3) == 0) step();
      else send(c);
    end
    rnd_mode = 1'b0;
    clear = 1'b0;
    drain();

    for (int i = 0; i < 300; i++)
      send(12'($urandom_range(0, 4095)) | 12'h001);
    drain();
    chk("errcnt_sat", err_count, 255);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_errcnt", err_count, 0);
    chk("clr_peak", peak_level, 0);

    out_ready = 1'b0;
    send(12'hF50);
    send(12'h3F0);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    chk("post_rst_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_unhash.md
# color_unhash

Inverse of the level-to-colour gradient used by the OLED bar and meter displays. Takes a stream of 12-bit RGB444 pixel colours and recovers the 5-bit level (0-31) that produced each one. It flags black (disabled) pixels and off-gradient colours, and keeps a decaying peak-hold level plus an error count. It sits between the display pixel path and the self-check and readback logic, behind a valid/ready handshake on both sides.

## Interface
- DECAY_CYCLES, default 16'd50000: cycles between one-step decrements of the peak-hold level; legal range 1..65535.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_color is valid.
- in_ready  out  1  block accepts in_color this cycle.
- in_color  in  12  pixel colour {R[11:8], G[7:4], B[3:0]}.
- out_valid  out  1  decoded result is valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_level  out  5  decoded level.
- out_enable  out  1  0 when the colour was 12'h000.
- out_err  out  1  colour is not black and not on the gradient.
- clear  in  1  synchronous clear of peak-hold, decay timer and error count.
- peak_level  out  5  peak-hold level.
- err_count  out  8  saturating count of delivered out_err results.

## Operation
- Decode, using R, G and B from in_color; first match wins:
  - 12'h000: out_enable=0, out_level=0, out_err=0.
  - B=0, G=F: out_level=31-R, so R=0 gives 31 and R=F gives 16. The shared colour 12'hFF0 decodes to 16.
  - B=0, R=F, G<=E: out_level=G, range 0..14.
  - Anything else: out_enable=1, out_err=1, out_level=0.
- Level 15 is never produced. Its forward colour collides with level 16.
- Pipeline has two register stages:
  - S1 holds the raw colour plus a valid bit.
  - S2 holds level, enable, err plus a valid bit. S2 drives the out_* ports directly from registers.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. This gives a combinational path from out_ready to in_ready, which is permitted.
- A beat is delivered when out_valid & out_ready.
- Peak-hold update, in priority order:
  1. clear: peak=0, timer=0, err_count=0.
  2. Delivered beat with out_enable=1, out_err=0 and out_level>peak: peak=out_level, timer=0.
  3. Otherwise, if peak>0:
     - When timer==DECAY_CYCLES-1: peak decrements by 1 and timer returns to 0.
     - Otherwise timer increments by 1.
  4. If peak==0, timer holds at 0.
- err_count increments on every delivered beat with out_err=1 and saturates at 255. clear has priority.
- A delivered beat that equals the current peak does not reset the timer.

## Timing
- Reset values: in_ready=1, out_valid=0, out_level=0, out_enable=0, out_err=0, peak_level=0, err_count=0. Timer is 0 and both stage valid bits are 0.
- Latency: a colour accepted at edge N is presented on out_* after edge N+1, i.e. two cycles.
- With out_ready held at 1, throughput is one beat per cycle.
- Stall: while out_valid=1 and out_ready=0, out_* are stable.
  - With both stages full, in_ready=0.
  - No beat is lost or duplicated.
- Simultaneous delivery and acceptance in the same cycle is a normal advance.
- Asserting rst_n low mid-stream discards both stages at once. In-flight beats are dropped, not delivered.
- clear does not affect the pipeline. A beat delivered in the same cycle as clear does not update peak or err_count.
- peak_level and err_count change only on clock edges and are registered outputs.

## Test plan
- Sweep: drive all 32 forward colours back to back with out_ready=1.
  - Levels appear two cycles after acceptance: 12'h0F0 gives 31, 12'hFF0 gives 16, 12'hF00 gives 0.
  - No out_err.
- Invalid and black: send 12'h000, then 12'h00F, then 12'h8F1.
  - Required outputs: enable=0/err=0, then err=1, then err=1.
  - err_count reaches 2.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 with four distinct colours.
  - in_ready falls after two acceptances.
  - On release, outputs arrive in order with no loss.
- Peak decay: DECAY_CYCLES=4; deliver 12'h0F0 (level 31), then idle.
  - peak_level=31, then 30 four cycles later, and so on to 0, where it holds.
  - A later level-20 beat sets peak to 20.
- Saturation and clear: deliver 300 invalid colours; err_count is 255.
  - Pulse clear; err_count=0 and peak_level=0 on the next edge.
- Reset mid-stream: drop rst_n with both stages full.
  - out_valid=0 and in_ready=1 immediately, before any clock edge.
  - No stale beat appears after release.
